button_conditioner: RTL and testbench

Conditions the five raw board push-buttons (C, U, D, R, L) before they reach the game logic. It provides:
- synchronisation and debouncing per button;
- one-cycle press pulses, with auto-repeat on the four direction buttons;
- short/long classification of the centre button, feeding `button_c_short` / `button_c_long` of `game_fsm`.

Sits between the board button pins and the `game` / `game_fsm` stage, in the `pixel_clk` domain.

---
 rtl/button_pkg.sv | 19 +
 rtl/button_debounce.sv | 59 +++++
 rtl/button_conditioner.sv | 151 +++++++++++++++
 tb/tb_button_conditioner.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared constants and types for the push-button conditioning path.
package button_pkg;

  // Bit positions of the five board buttons within the button vectors
  localparam int BTN_C   = 0;
  localparam int BTN_U   = 1;
  localparam int BTN_D   = 2;
  localparam int BTN_R   = 3;
  localparam int BTN_L   = 4;
  localparam int NUM_BTN = 5;

  // Centre-button press classification states
  typedef enum logic [1:0] {
    IDLE,
    HELD,
    LONG_FIRED
  } c_press_state_t;

endpackage

// File: rtl/button_debounce.sv
// One button: 2-FF synchroniser, debounce counter, stable level and a
// one-cycle press pulse aligned with the first cycle the level reads 1.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 360_000
) (
  input  logic pixel_clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // The sample has disagreed with the stable level long enough to flip it
  assign accept = (sync_p1 != level) && (cnt == CNT_LAST);

  // Two-stage synchroniser for the asynchronous pin
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: count consecutive disagreeing samples, toggle the level on the last one
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= accept && !level;
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt_sat_inc(cnt);
      end
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Conditions the five board buttons: debounced levels, press pulses with
// auto-repeat on the direction buttons, and short/long centre classification.
module button_conditioner
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 360_000,
  parameter int LONG_PRESS_CYCLES = 36_000_000,
  parameter int REPEAT_DELAY      = 18_000_000,
  parameter int REPEAT_PERIOD     = 3_600_000
) (
  input  logic               pixel_clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw_i,
  output logic [NUM_BTN-1:0] btn_level_o,
  output logic [NUM_BTN-1:0] btn_press_o,
  output logic               button_c_short_o,
  output logic               button_c_long_o
);

  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_DELAY_C  = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0] REP_PERIOD_C = REP_W'(REPEAT_PERIOD);
  localparam logic [REP_W-1:0] REP_SAT      = REP_W'(REP_MAX);
  localparam bit               REPEAT_EN    = (REPEAT_DELAY != 0);

  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LONG = HOLD_W'(LONG_PRESS_CYCLES);

  logic [NUM_BTN-1:0] deb_level;
  logic [NUM_BTN-1:0] deb_press;
  logic [NUM_BTN-1:0] rep_hit;

  c_press_state_t    c_state;
  c_press_state_t    c_state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_cnt_nxt;
  logic              c_short;
  logic              c_long;

  function automatic logic [REP_W-1:0] rep_sat_inc(input logic [REP_W-1:0] v);
    return (v == REP_SAT) ? v : v + REP_W'(1);
  endfunction

  function automatic logic [HOLD_W-1:0] hold_sat_inc(input logic [HOLD_W-1:0] v);
    return (v == HOLD_LONG) ? v : v + HOLD_W'(1);
  endfunction

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .pixel_clk(pixel_clk),
      .rst_n    (rst_n),
      .btn_raw  (btn_raw_i[i]),
      .level    (deb_level[i]),
      .press    (deb_press[i])
    );
  end

  // The centre button never auto-repeats
  assign rep_hit[BTN_C] = 1'b0;

  for (genvar i = BTN_U; i <= BTN_L; i++) begin : g_rep
    // rep_cnt holds the number of cycles since the last press or repeat pulse
    logic [REP_W-1:0] rep_cnt;
    logic             rep_first;
    logic             rep_armed;

    assign rep_hit[i] = REPEAT_EN && rep_armed && deb_level[i] &&
                        (rep_cnt == (rep_first ? REP_DELAY_C : REP_PERIOD_C));

    // Auto-repeat timer: restart on press, cancel on release, reload on each repeat
    always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
        rep_cnt   <= '0;
        rep_first <= 1'b1;
        rep_armed <= 1'b0;
      end else if (deb_press[i]) begin
        rep_cnt   <= REP_W'(1);
        rep_first <= 1'b1;
        rep_armed <= 1'b1;
      end else if (!deb_level[i]) begin
        rep_cnt   <= '0;
        rep_first <= 1'b1;
        rep_armed <= 1'b0;
      end else if (rep_hit[i]) begin
        rep_cnt   <= REP_W'(1);
        rep_first <= 1'b0;
      end else if (rep_armed) begin
        rep_cnt <= rep_sat_inc(rep_cnt);
      end
    end
  end

  // Centre FSM state and hold counter registers
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      c_state  <= IDLE;
      hold_cnt <= '0;
    end else begin
      c_state  <= c_state_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  // Centre FSM next state and short/long pulses; hold_cnt equals cycles elapsed since the press pulse
  always_comb begin
    c_state_nxt  = c_state;
    hold_cnt_nxt = hold_cnt;
    c_short      = 1'b0;
    c_long       = 1'b0;
    unique case (c_state)
      IDLE: begin
        hold_cnt_nxt = '0;
        if (deb_press[BTN_C]) begin
          c_state_nxt  = HELD;
          hold_cnt_nxt = HOLD_W'(1);
        end
      end
      HELD: begin
        if (!deb_level[BTN_C]) begin
          c_short      = 1'b1;
          c_state_nxt  = IDLE;
          hold_cnt_nxt = '0;
        end else if (hold_cnt == HOLD_LONG) begin
          c_long      = 1'b1;
          c_state_nxt = LONG_FIRED;
        end else begin
          hold_cnt_nxt = hold_sat_inc(hold_cnt);
        end
      end
      LONG_FIRED: begin
        if (!deb_level[BTN_C]) begin
          c_state_nxt  = IDLE;
          hold_cnt_nxt = '0;
        end
      end
      default: begin
        c_state_nxt  = IDLE;
        hold_cnt_nxt = '0;
      end
    endcase
  end

  assign btn_level_o      = deb_level;
  assign btn_press_o      = deb_press | rep_hit;
  assign button_c_short_o = c_short;
  assign button_c_long_o  = c_long;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with shortened timing parameters.
module tb_button_conditioner;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int RD   = 10;
  localparam int RP   = 5;
  localparam int LAT  = DEB + 2;

  localparam logic [4:0] M_C = 5'b00001;
  localparam logic [4:0] M_U = 5'b00010;
  localparam logic [4:0] M_D = 5'b00100;
  localparam logic [4:0] M_R = 5'b01000;
  localparam logic [4:0] M_L = 5'b10000;

  logic       pixel_clk = 1'b0;
  logic       rst_n;
  logic [4:0] btn_raw;
  logic [4:0] level;
  logic [4:0] press;
  logic       c_short;
  logic       c_long;

  int cyc    = 0;
  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int         cyc;
    logic [4:0] press;
    logic       c_short;
    logic       c_long;
    logic [4:0] level;
  } ev_t;

  ev_t        sb[$];
  logic [4:0] exp_level = '0;

  button_conditioner #(
    .DEBOUNCE_CYCLES  (DEB),
    .LONG_PRESS_CYCLES(LONG),
    .REPEAT_DELAY     (RD),
    .REPEAT_PERIOD    (RP)
  ) dut (
    .pixel_clk       (pixel_clk),
    .rst_n           (rst_n),
    .btn_raw_i       (btn_raw),
    .btn_level_o     (level),
    .btn_press_o     (press),
    .button_c_short_o(c_short),
    .button_c_long_o (c_long)
  );

  always #5 pixel_clk = ~pixel_clk;

  always @(posedge pixel_clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, act, exp);
    end
  endtask

  // Expected output event at cycle c; level is the expected vector from c onward
  task automatic push_ev(input int c, input logic [4:0] p, input logic s, input logic l,
                         input logic [4:0] lv);
    ev_t e;
    e.cyc     = c;
    e.press   = p;
    e.c_short = s;
    e.c_long  = l;
    e.level   = lv;
    sb.push_back(e);
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge pixel_clk);
      #1;
    end
  endtask

  // Compare every output every cycle; pulses are expected only where an event is queued
  always @(negedge pixel_clk) begin : monitor
    logic [4:0] exp_press;
    logic       exp_short;
    logic       exp_long;
    exp_press = '0;
    exp_short = 1'b0;
    exp_long  = 1'b0;
    if (!rst_n) begin
      exp_level = '0;
    end else begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        check_eq("sb_late", sb[0].cyc, cyc);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        exp_press = sb[0].press;
        exp_short = sb[0].c_short;
        exp_long  = sb[0].c_long;
        exp_level = sb[0].level;
        void'(sb.pop_front());
      end
    end
    check_eq("level", level, exp_level);
    check_eq("press", press, exp_press);
    check_eq("c_short", c_short, exp_short);
    check_eq("c_long", c_long, exp_long);
  end

  initial begin
    int t0;
    int p;
    int tr;
    btn_raw = '0;
    rst_n   = 1'b0;
    repeat (3) @(posedge pixel_clk);
    #1;
    rst_n = 1'b1;
    goto(cyc + 5);

    // Clean press of U, released before any repeat
    t0 = cyc;
    btn_raw = btn_raw | M_U;
    push_ev(t0 + LAT, M_U, 1'b0, 1'b0, M_U);
    goto(t0 + 7);
    btn_raw = btn_raw & ~M_U;
    push_ev(t0 + 7 + LAT, '0, 1'b0, 1'b0, '0);
    goto(t0 + 25);

    // Glitch on R one cycle shorter than the debounce window
    t0 = cyc;
    btn_raw = btn_raw | M_R;
    goto(t0 + DEB - 1);
    btn_raw = btn_raw & ~M_R;
    goto(t0 + 20);

    // D pulse exactly DEBOUNCE_CYCLES long is accepted
    t0 = cyc;
    btn_raw = btn_raw | M_D;
    push_ev(t0 + LAT, M_D, 1'b0, 1'b0, M_D);
    goto(t0 + DEB);
    btn_raw = btn_raw & ~M_D;
    push_ev(t0 + 2 * DEB + 2, '0, 1'b0, 1'b0, '0);
    goto(t0 + 25);

    // U and R pressed together pulse in the same cycle
    t0 = cyc;
    btn_raw = btn_raw | M_U | M_R;
    push_ev(t0 + LAT, M_U | M_R, 1'b0, 1'b0, M_U | M_R);
    goto(t0 + 7);
    btn_raw = btn_raw & ~(M_U | M_R);
    push_ev(t0 + 7 + LAT, '0, 1'b0, 1'b0, '0);
    goto(t0 + 25);

    // Auto-repeat on L: level high for 40 cycles from P
    t0 = cyc;
    p  = t0 + LAT;
    btn_raw = btn_raw | M_L;
    push_ev(p, M_L, 1'b0, 1'b0, M_L);
    for (int k = RD; k < 40; k += RP) push_ev(p + k, M_L, 1'b0, 1'b0, M_L);
    goto(t0 + 40);
    btn_raw = btn_raw & ~M_L;
    push_ev(p + 40, '0, 1'b0, 1'b0, '0);
    goto(p + 55);

    // Long press of C: level high for 30 cycles
    t0 = cyc;
    p  = t0 + LAT;
    btn_raw = btn_raw | M_C;
    push_ev(p, M_C, 1'b0, 1'b0, M_C);
    push_ev(p + LONG, '0, 1'b0, 1'b1, M_C);
    goto(t0 + 30);
    btn_raw = btn_raw & ~M_C;
    push_ev(p + 30, '0, 1'b0, 1'b0, '0);
    goto(p + 45);

    // Short press of C: level high for 10 cycles
    t0 = cyc;
    p  = t0 + LAT;
    btn_raw = btn_raw | M_C;
    push_ev(p, M_C, 1'b0, 1'b0, M_C);
    goto(t0 + 10);
    btn_raw = btn_raw & ~M_C;
    push_ev(p + 10, '0, 1'b1, 1'b0, '0);
    goto(p + 25);

    // Reset while C is held: old press discarded, new press after reset release
    t0 = cyc;
    p  = t0 + LAT;
    btn_raw = btn_raw | M_C;
    push_ev(p, M_C, 1'b0, 1'b0, M_C);
    goto(p + 10);
    rst_n = 1'b0;
    goto(p + 13);
    rst_n = 1'b1;
    tr = cyc;
    push_ev(tr + LAT, M_C, 1'b0, 1'b0, M_C);
    goto(tr + 8);
    btn_raw = btn_raw & ~M_C;
    push_ev(tr + 8 + LAT, '0, 1'b1, 1'b0, '0);
    goto(tr + 40);

    check_eq("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
